multibyte_add_sequencer: RTL

- Multi-precision add controller: performs an NBYTES×8-bit add by sequencing one shared 8-bit full adder (A, B, Cin -> Sum, Cout) one byte per clock, LSB first.
- Carry is chained between bytes through an internal register.
- Sits between a requester (start/done handshake) and the existing combinational 8-bit full adder, which is instantiated outside this block and driven through the add_* ports.

---
 rtl/multibyte_add_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer
// Sequences one shared external 8-bit full adder over NBYTES limbs,
// least-significant byte first, chaining the carry through a register.
// A start handshake latches the operands. The result is valid when done pulses,
// and it holds until the next accepted start.
// Optional build macro: MULTIBYTE_ADD_SUB_EN adds a 'sub' input that selects
// A-B (two's complement: inverted B bytes, initial carry forced to 1).

module multibyte_add_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   A,
   input  logic [8*NBYTES-1:0]   B,
   input  logic                  Cin,
`ifdef MULTIBYTE_ADD_SUB_EN
   input  logic                  sub,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   Sum,
   output logic                  Cout,
   output logic [7:0]            add_A,
   output logic [7:0]            add_B,
   output logic                  add_Cin,
   input  logic [7:0]            add_Sum,
   input  logic                  add_Cout
);

   // Byte index is at least one bit wide so NBYTES=1 still elaborates cleanly.
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [IW-1:0]         idx_reg, idx_next;
   logic                  carry_reg, carry_next;
   logic                  cout_reg, cout_next;
   logic [8*NBYTES-1:0]   a_lat_reg, a_lat_next;
   logic [8*NBYTES-1:0]   b_lat_reg, b_lat_next;
   logic                  clear_sum;
   logic                  sub_lat_reg;
   logic [7:0]            a_byte;
   logic [7:0]            b_byte;

`ifdef MULTIBYTE_ADD_SUB_EN
   logic                  sub_lat_next;

   // Subtract-mode flag, captured together with the operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_lat_reg <= 1'b0;
      end else begin
         sub_lat_reg <= sub_lat_next;
      end
   end
`else
   assign sub_lat_reg = 1'b0;
`endif

   // Current limb of each latched operand, selected by the byte index.
   assign a_byte = a_lat_reg[{idx_reg, 3'b000} +: 8];
   assign b_byte = b_lat_reg[{idx_reg, 3'b000} +: 8];

   // Control state, index, carry chain, final carry and operand latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         a_lat_reg <= '0;
         b_lat_reg <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
         a_lat_reg <= a_lat_next;
         b_lat_reg <= b_lat_next;
      end
   end

   // Next-state logic and shared-adder drive. The adder sees zeros outside RUN.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      a_lat_next = a_lat_reg;
      b_lat_next = b_lat_reg;
      clear_sum  = 1'b0;
      add_A      = 8'h00;
      add_B      = 8'h00;
      add_Cin    = 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
      sub_lat_next = sub_lat_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_lat_next = A;
               b_lat_next = B;
               idx_next   = '0;
               cout_next  = 1'b0;
               clear_sum  = 1'b1;
`ifdef MULTIBYTE_ADD_SUB_EN
               sub_lat_next = sub;
               // Subtract = A + ~B + 1. The +1 comes from the initial carry.
               carry_next   = sub ? 1'b1 : Cin;
`else
               carry_next   = Cin;
`endif
               state_next = RUN;
            end
         end
         RUN: begin
            add_A      = a_byte;
            add_B      = b_byte ^ {8{sub_lat_reg}};
            add_Cin    = carry_reg;
            carry_next = add_Cout;
            if (idx_reg == LAST_IDX) begin
               // Index stays on the last limb so it never wraps.
               cout_next  = add_Cout;
               state_next = DONE;
            end else begin
               idx_next = idx_reg + IW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One result register per limb. A limb is written only when it is the active one.
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_limb
         logic [7:0] limb_reg;

         // Capture the adder sum for this limb, or clear it on a new start.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               limb_reg <= 8'h00;
            end else if (clear_sum) begin
               limb_reg <= 8'h00;
            end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
               limb_reg <= add_Sum;
            end
         end

         assign Sum[gi*8 +: 8] = limb_reg;
      end
   endgenerate

   assign Cout = cout_reg;
   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);

endmodule
